// File: rtl/spi_block_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_block_reader: fetches a short response or a token/data/CRC16 block   |
// | through the SPI byte engine into a word-wide buffer. Optional SPI_CRC_EN |
// | adds CRC-16/XMODEM checking.                                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_block_reader #(
   parameter int         BLK_BYTES   = 512,
   parameter int         OUT_W       = 8,
   parameter int         MAX_RETRIES = 32767,
   parameter logic [7:0] TOKEN       = 8'hFE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_start,
   input  logic [15:0]      cmd_len,
   input  logic             cmd_long,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status,
   output logic             spi_start,
   input  logic [7:0]       spi_data,
   input  logic             spi_rdy,
   input  logic             rd_req,
   input  logic             rd_rewind,
   output logic [OUT_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_last
);

   localparam int c_BPW     = OUT_W / 8;
   localparam int c_LOG_BPW = $clog2(c_BPW);
   localparam int c_DEPTH   = BLK_BYTES / c_BPW;
   localparam int c_ADDR_W  = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
   localparam int c_LANE_W  = (c_BPW > 1) ? c_LOG_BPW : 1;
   localparam int c_RET_W   = $clog2(MAX_RETRIES + 1);
   localparam logic [c_LANE_W-1:0] c_LANE_MAX = c_LANE_W'(c_BPW - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_WAIT   = 3'd2,
      S_HUNT   = 3'd3,
      S_DATA   = 3'd4,
      S_CRC    = 3'd5,
      S_FINISH = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      PH_HUNT = 2'd0,
      PH_DATA = 2'd1,
      PH_CRC  = 2'd2
   } phase_t;

   state_t               r_state, w_state_nxt;
   phase_t               r_phase;
   logic                 r_busy, r_done, r_long, r_crc_hi;
   logic [1:0]           r_status, r_fin, w_final_status;
   logic [15:0]          r_len, r_cnt, w_cnt_nxt;
   logic [7:0]           r_byte;
   logic [c_RET_W-1:0]   r_retries;
   logic [c_LANE_W-1:0]  r_lane;
   logic [c_ADDR_W-1:0]  r_wptr, r_rptr, r_last_word;
   logic [OUT_W-1:0]     r_mem [c_DEPTH];
   logic [OUT_W-1:0]     r_mem_q, r_rd_data, w_word;
   logic                 r_v1, r_l1, r_rd_valid, r_rd_last;
   logic                 w_accept, w_len_bad, w_retry_hit, w_data_end, w_we, w_rd_go;

`ifdef SPI_CRC_EN
   logic [15:0] r_crc_calc, r_crc_rx;

   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] din);
      logic [15:0] c;
      c = crc_in ^ {din, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   assign w_final_status = (r_long && (r_fin == 2'd0) && (r_crc_rx != r_crc_calc)) ? 2'd2 : r_fin;
`else
   assign w_final_status = r_fin;
`endif

   // A start arriving alongside done belongs to the finished capture and is dropped.
   assign w_accept    = cmd_start && !r_done;
   assign w_len_bad   = (cmd_len == 16'd0) || ({1'b0, cmd_len} > 17'(BLK_BYTES)) ||
                        ((cmd_len & 16'(c_BPW - 1)) != 16'd0);
   assign w_retry_hit = (c_RET_W'(r_retries + 1'b1) == c_RET_W'(MAX_RETRIES));
   assign w_cnt_nxt   = r_cnt + 16'd1;
   assign w_data_end  = (w_cnt_nxt == r_len);
   assign w_we        = (r_state == S_DATA) && (r_lane == c_LANE_MAX);
   assign w_rd_go     = rd_req && !rd_rewind && !r_busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      spi_start   = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_len_bad ? S_FINISH : S_REQ;
         S_REQ: begin
            spi_start   = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (spi_rdy) begin
               if (r_phase == PH_CRC)
                  w_state_nxt = S_CRC;
               else if ((r_phase == PH_DATA) || (spi_data != 8'hFF && !r_long))
                  w_state_nxt = S_DATA;
               else
                  w_state_nxt = S_HUNT;
            end
         end
         S_HUNT: begin
            if (r_byte == 8'hFF)      w_state_nxt = w_retry_hit ? S_FINISH : S_REQ;
            else if (r_byte == TOKEN) w_state_nxt = S_REQ;
            else                      w_state_nxt = S_FINISH;
         end
         S_DATA:   w_state_nxt = (w_data_end && !r_long) ? S_FINISH : S_REQ;
         S_CRC:    w_state_nxt = r_crc_hi ? S_REQ : S_FINISH;
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase     <= PH_HUNT;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_long      <= 1'b0;
         r_crc_hi    <= 1'b0;
         r_status    <= 2'd0;
         r_fin       <= 2'd0;
         r_len       <= 16'd0;
         r_cnt       <= 16'd0;
         r_byte      <= 8'd0;
         r_retries   <= '0;
         r_lane      <= '0;
         r_wptr      <= '0;
         r_last_word <= '0;
`ifdef SPI_CRC_EN
         r_crc_calc  <= 16'd0;
         r_crc_rx    <= 16'd0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy      <= 1'b1;
                  r_status    <= 2'd0;
                  r_fin       <= w_len_bad ? 2'd3 : 2'd0;
                  r_len       <= cmd_len;
                  r_long      <= cmd_long;
                  r_cnt       <= 16'd0;
                  r_retries   <= '0;
                  r_lane      <= '0;
                  r_wptr      <= '0;
                  r_phase     <= PH_HUNT;
                  r_crc_hi    <= 1'b1;
                  r_last_word <= c_ADDR_W'((cmd_len >> c_LOG_BPW) - 16'd1);
`ifdef SPI_CRC_EN
                  r_crc_calc  <= 16'd0;
`endif
               end
            end
            S_WAIT: if (spi_rdy) r_byte <= spi_data;
            S_HUNT: begin
               if (r_byte == 8'hFF) begin
                  if (w_retry_hit) begin
                     r_retries <= c_RET_W'(MAX_RETRIES);
                     r_fin     <= 2'd1;
                  end else begin
                     r_retries <= r_retries + 1'b1;
                  end
               end else if (r_byte == TOKEN) begin
                  r_phase <= PH_DATA;
               end else begin
                  r_fin <= 2'd3;
               end
            end
            S_DATA: begin
               r_cnt   <= w_cnt_nxt;
               r_phase <= (w_data_end && r_long) ? PH_CRC : PH_DATA;
               if (r_lane == c_LANE_MAX) begin
                  r_lane <= '0;
                  r_wptr <= r_wptr + 1'b1;
               end else begin
                  r_lane <= r_lane + 1'b1;
               end
`ifdef SPI_CRC_EN
               r_crc_calc <= crc16_byte(r_crc_calc, r_byte);
`endif
            end
            S_CRC: begin
               r_crc_hi <= 1'b0;
`ifdef SPI_CRC_EN
               if (r_crc_hi) r_crc_rx[15:8] <= r_byte;
               else          r_crc_rx[7:0]  <= r_byte;
`endif
            end
            S_FINISH: begin
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_status <= w_final_status;
            end
            default: ;
         endcase
      end
   end

   // Bytes arrive little-endian; the final byte of a word goes straight to the RAM write.
   generate
      if (c_BPW > 1) begin : g_pack
         logic [OUT_W-9:0] r_pack;
         always_ff @(posedge clk) begin
            if (r_state == S_DATA && r_lane != c_LANE_MAX)
               r_pack[r_lane*8 +: 8] <= r_byte;
         end
         assign w_word = {r_byte, r_pack};
      end else begin : g_nopack
         assign w_word = r_byte;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_we)    r_mem[r_wptr] <= w_word;
      if (w_rd_go) r_mem_q <= r_mem[r_rptr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rptr     <= '0;
         r_v1       <= 1'b0;
         r_l1       <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_v1       <= w_rd_go;
         r_l1       <= w_rd_go && (r_rptr == r_last_word);
         r_rd_valid <= r_v1;
         r_rd_last  <= r_l1;
         if (r_v1) r_rd_data <= r_mem_q;
         if (r_state == S_FINISH || rd_rewind)
            r_rptr <= '0;
         else if (w_rd_go)
            r_rptr <= (r_rptr == r_last_word) ? '0 : r_rptr + 1'b1;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign status   = r_status;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign rd_last  = r_rd_last;

endmodule
`default_nettype wire
